// File: rtl/gpio_input_conditioner_pkg.sv
// rtl/gpio_input_conditioner_pkg.sv - shared register offsets for the GPIO input conditioner
package gpio_input_conditioner_pkg;

   localparam logic [1:0] REG_STATUS  = 2'd0;
   localparam logic [1:0] REG_IRQ_EN  = 2'd1;
   localparam logic [1:0] REG_PENDING = 2'd2;
   localparam logic [1:0] REG_DEB_EN  = 2'd3;

endpackage

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - per-pin synchroniser, debounce counter and clean flop
module gpio_debounce_bit #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_in,
   input  logic deb_en,
   output logic clean
);

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   sync;
   logic [7:0]             count;

   assign sync = sync_chain[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_chain <= '0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], pin_in};
      end
   end

   // clean only moves after DEBOUNCE_CYCLES consecutive mismatching samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         clean <= 1'b0;
      end else if (!deb_en) begin
         count <= '0;
         clean <= sync;
      end else if (sync == clean) begin
         count <= '0;
      end else if (count == CNT_LAST) begin
         count <= '0;
         clean <= sync;
      end else begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: rtl/gpio_input_conditioner.sv
// rtl/gpio_input_conditioner.sv - pad input conditioning, edge capture and interrupt registers
module gpio_input_conditioner
   import gpio_input_conditioner_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       address,
   input  logic [31:0]       write_data,
   output logic [31:0]       read_data,
   input  logic [WIDTH-1:0]  pins_in,
   output logic [WIDTH-1:0]  pins_clean,
   output logic              irq
);

   logic [1:0]           reg_sel;
   logic [WIDTH-1:0]     pins_clean_d;
   logic [WIDTH-1:0]     pending;
   logic [WIDTH-1:0]     deb_en;
   logic [2*WIDTH-1:0]   irq_en;
   logic [WIDTH-1:0]     rise;
   logic [WIDTH-1:0]     fall;
   logic [WIDTH-1:0]     clr;
   logic                 unused_bits;

   assign reg_sel     = address[3:2];
   assign unused_bits = &{1'b0, address[31:4], address[1:0], write_data[31:2*WIDTH]};

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      gpio_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk    (clk),
         .reset  (reset),
         .pin_in (pins_in[i]),
         .deb_en (deb_en[i]),
         .clean  (pins_clean[i])
      );
   end

   assign rise = pins_clean & ~pins_clean_d;
   assign fall = ~pins_clean & pins_clean_d;
   assign clr  = (write && reg_sel == REG_PENDING) ? write_data[WIDTH-1:0] : '0;
   assign irq  = |pending;

   // new edges are ORed in after the clear so a same-cycle set survives
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pins_clean_d <= '0;
         pending      <= '0;
         irq_en       <= '0;
         deb_en       <= '0;
      end else begin
         pins_clean_d <= pins_clean;
         pending      <= (pending & ~clr) | (rise & irq_en[WIDTH-1:0]) |
                         (fall & irq_en[2*WIDTH-1:WIDTH]);
         if (write && reg_sel == REG_IRQ_EN) begin
            irq_en <= write_data[2*WIDTH-1:0];
         end
         if (write && reg_sel == REG_DEB_EN) begin
            deb_en <= write_data[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      read_data = '0;
      if (read) begin
         case (reg_sel)
            REG_STATUS:  read_data = 32'(pins_clean);
            REG_IRQ_EN:  read_data = 32'(irq_en);
            REG_PENDING: read_data = 32'(pending);
            REG_DEB_EN:  read_data = 32'(deb_en);
            default:     read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb/tb_gpio_input_conditioner.sv - randomized and directed bench with behavioural model
module tb_gpio_input_conditioner;

   localparam int W  = 8;
   localparam int S  = 2;
   localparam int DC = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          read;
   logic          write;
   logic [31:0]   address;
   logic [31:0]   write_data;
   logic [31:0]   read_data;
   logic [W-1:0]  pins_in;
   logic [W-1:0]  pins_clean;
   logic          irq;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   gpio_input_conditioner #(
      .WIDTH           (W),
      .SYNC_STAGES     (S),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .read       (read),
      .write      (write),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .pins_in    (pins_in),
      .pins_clean (pins_clean),
      .irq        (irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pin history, window of recent samples, spec-level register rules
   logic [W-1:0]   m_pipe [S];
   logic [W-1:0]   win_sync [DC];
   logic [W-1:0]   win_deb [DC];
   logic [W-1:0]   m_clean, m_clean_d, m_pending, m_deb;
   logic [2*W-1:0] m_irq_en;

   always @(posedge clk or posedge reset) begin : model
      logic [W-1:0] sync_now, rise, fall, clr, nxt;
      bit           all_mm;
      if (reset) begin
         for (int j = 0; j < S; j++) m_pipe[j] = '0;
         for (int j = 0; j < DC; j++) begin
            win_sync[j] = '0;
            win_deb[j]  = '0;
         end
         m_clean   = '0;
         m_clean_d = '0;
         m_pending = '0;
         m_deb     = '0;
         m_irq_en  = '0;
      end else begin
         sync_now = m_pipe[S-1];
         rise     = m_clean & ~m_clean_d;
         fall     = ~m_clean & m_clean_d;
         clr      = (write && address[3:2] == 2'd2) ? write_data[W-1:0] : '0;
         for (int j = DC-1; j > 0; j--) begin
            win_sync[j] = win_sync[j-1];
            win_deb[j]  = win_deb[j-1];
         end
         win_sync[0] = sync_now;
         win_deb[0]  = m_deb;
         for (int i = 0; i < W; i++) begin
            if (!m_deb[i]) begin
               nxt[i] = sync_now[i];
            end else begin
               all_mm = 1'b1;
               for (int j = 0; j < DC; j++)
                  if (!win_deb[j][i] || win_sync[j][i] == m_clean[i]) all_mm = 1'b0;
               nxt[i] = all_mm ? sync_now[i] : m_clean[i];
            end
         end
         m_pending = (m_pending & ~clr) | (rise & m_irq_en[W-1:0]) | (fall & m_irq_en[2*W-1:W]);
         if (write && address[3:2] == 2'd1) m_irq_en = write_data[2*W-1:0];
         if (write && address[3:2] == 2'd3) m_deb = write_data[W-1:0];
         for (int j = S-1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
         m_pipe[0] = pins_in;
         m_clean_d = m_clean;
         m_clean   = nxt;
      end
   end

   always @(negedge clk) begin : compare
      logic [31:0] exp_rd;
      exp_rd = '0;
      if (read) begin
         case (address[3:2])
            2'd0: exp_rd = {24'd0, m_clean};
            2'd1: exp_rd = {16'd0, m_irq_en};
            2'd2: exp_rd = {24'd0, m_pending};
            default: exp_rd = {24'd0, m_deb};
         endcase
      end
      check("model_pins_clean", {24'd0, pins_clean}, {24'd0, m_clean});
      check("model_irq", {31'd0, irq}, {31'd0, |m_pending});
      check("model_read_data", read_data, exp_rd);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
      write      = 1'b1;
      address    = {28'd0, r, 2'b00};
      write_data = d;
      step(1);
      write      = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
      read    = 1'b1;
      address = {28'd0, r, 2'b00};
      #1;
      d    = read_data;
      read = 1'b0;
   endtask

   initial begin
      reset = 1'b1; read = 1'b0; write = 1'b0;
      address = '0; write_data = '0; pins_in = 8'hFF;

      // reset with all pins high
      step(3);
      check("rst_irq", {31'd0, irq}, 32'd0);
      bus_read(2'd0, rd); check("rst_status", rd, 32'd0);
      reset = 1'b0;
      bus_read(2'd0, rd); check("release_status", rd, 32'd0);
      step(2);
      bus_read(2'd0, rd); check("status_edge2", rd, 32'd0);
      step(1);
      bus_read(2'd0, rd); check("status_edge3", rd, 32'h0000_00FF);
      bus_read(2'd2, rd); check("release_pending", rd, 32'd0);
      step(3);
      check("release_irq", {31'd0, irq}, 32'd0);

      // bypass rise latency
      pins_in = 8'h00;
      step(6);
      bus_write(2'd1, 32'h0000_0001);
      pins_in = 8'h01;
      step(3);
      check("bypass_clean_edge3", {31'd0, pins_clean[0]}, 32'd1);
      check("bypass_irq_edge3", {31'd0, irq}, 32'd0);
      step(1);
      check("bypass_irq_edge4", {31'd0, irq}, 32'd1);
      bus_read(2'd2, rd); check("bypass_pending", rd, 32'h01);

      // write-1-to-clear, then a rise coinciding with a clear
      bus_write(2'd2, 32'h0000_0001);
      check("w1c_irq", {31'd0, irq}, 32'd0);
      bus_write(2'd1, 32'h0000_0101);
      pins_in = 8'h00;
      step(6);
      bus_read(2'd2, rd); check("fall_pending", rd, 32'h01);
      pins_in = 8'h01;
      step(3);
      bus_write(2'd2, 32'h0000_0001);
      bus_read(2'd2, rd); check("set_beats_clear", rd, 32'h01);
      check("set_beats_clear_irq", {31'd0, irq}, 32'd1);
      bus_write(2'd1, 32'h0000_0001);

      // debounce: short pulse rejected, long pulse accepted
      pins_in = 8'h00;
      step(6);
      bus_write(2'd2, 32'h0000_00FF);
      bus_write(2'd3, 32'h0000_0001);
      pins_in = 8'h01;
      step(3);
      pins_in = 8'h00;
      step(10);
      check("short_pulse_clean", {31'd0, pins_clean[0]}, 32'd0);
      check("short_pulse_irq", {31'd0, irq}, 32'd0);
      pins_in = 8'h01;
      step(5);
      check("long_pulse_edge5", {31'd0, pins_clean[0]}, 32'd0);
      step(1);
      check("long_pulse_edge6", {31'd0, pins_clean[0]}, 32'd1);
      step(4);
      pins_in = 8'h00;
      step(5);
      check("long_fall_edge5", {31'd0, pins_clean[0]}, 32'd1);
      step(1);
      check("long_fall_edge6", {31'd0, pins_clean[0]}, 32'd0);

      // fall-only enable
      bus_write(2'd2, 32'h0000_00FF);
      bus_write(2'd3, 32'h0000_0000);
      bus_write(2'd1, 32'h0000_0100);
      pins_in = 8'h01;
      step(6);
      bus_read(2'd2, rd); check("fall_only_rise", rd, 32'h00);
      pins_in = 8'h00;
      step(6);
      bus_read(2'd2, rd); check("fall_only_fall", rd, 32'h01);

      // reset mid-count
      bus_write(2'd2, 32'h0000_00FF);
      bus_write(2'd3, 32'h0000_0001);
      bus_write(2'd1, 32'h0000_0101);
      pins_in = 8'h01;
      step(4);
      reset = 1'b1;
      #1;
      check("midreset_clean", {24'd0, pins_clean}, 32'd0);
      check("midreset_irq", {31'd0, irq}, 32'd0);
      step(2);
      reset = 1'b0;
      step(8);
      bus_read(2'd2, rd); check("post_reset_pending", rd, 32'd0);
      bus_read(2'd1, rd); check("post_reset_irq_en", rd, 32'd0);
      bus_read(2'd0, rd); check("post_reset_status", rd, 32'h01);
      check("post_reset_irq", {31'd0, irq}, 32'd0);

      // randomized traffic against the model
      for (int it = 0; it < 3000; it++) begin
         if ($urandom_range(0, 99) < 15) pins_in[$urandom_range(0, W-1)] ^= 1'b1;
         read       = ($urandom_range(0, 1) == 1);
         write      = ($urandom_range(0, 9) == 0);
         address    = $urandom;
         write_data = $urandom;
         reset      = ($urandom_range(0, 499) == 0);
         step(1);
      end
      reset = 1'b0; read = 1'b0; write = 1'b0;
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
Sits between the chip input pads and the GPIO register block. It conditions each raw input bit:
- synchronises it to `clk`;
- optionally debounces it;
- feeds the clean value downstream on `pins_clean`.

It also detects rising and falling edges per pin, latches them in a pending register, and raises a level interrupt to the core. Software reaches it through the same simple read/write/address bus as the other peripherals.

Parameters:
- WIDTH, 8, number of input pins conditioned.
- SYNC_STAGES, 2, synchroniser flop depth (legal values 2..3).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before `pins_clean` follows (legal values 2..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- read  in  1  bus read strobe.
- write  in  1  bus write strobe.
- address  in  32  byte address; only [3:2] decoded.
- write_data  in  32  bus write data.
- read_data  out  32  bus read data; 0 when read=0.
- pins_in  in  WIDTH  raw asynchronous pad inputs.
- pins_clean  out  WIDTH  synchronised/debounced value, to GPIO block gpios_in.
- irq  out  1  level interrupt = OR of pending bits.

Behaviour:
- Reset (async, active-high) clears all state: sync chain, `pins_clean`, debounce counters, `pins_clean_d`, IRQ_EN, PENDING, DEB_EN. Consequently `irq`=0 and `read_data`=0.
- Synchroniser: `pins_in` passes through SYNC_STAGES flops; the output is `sync`.
- Debounce, per pin, when DEB_EN[i]=1:
  - An 8-bit counter runs.
  - If sync[i]==pins_clean[i], the counter is cleared.
  - Otherwise, if counter==DEBOUNCE_CYCLES-1, pins_clean[i] takes sync[i] and the counter clears.
  - Otherwise the counter increments.
  - A mismatch shorter than DEBOUNCE_CYCLES cycles never reaches `pins_clean`.
- Debounce bypass, when DEB_EN[i]=0: pins_clean[i] <= sync[i] every cycle, and the counter is held at 0.
- Toggling DEB_EN mid-count clears that pin's counter; no glitch appears on `pins_clean`.
- Edge detect uses `pins_clean_d` (`pins_clean` registered once):
  - rise = pins_clean & ~pins_clean_d.
  - fall = ~pins_clean & pins_clean_d.
- Pending update, each cycle: PENDING <= (PENDING & ~clr) | (rise & IRQ_EN[7:0]) | (fall & IRQ_EN[15:8]).
  - Set wins over a clear of the same bit in the same cycle.
- `irq` = |PENDING, driven combinationally from the register, with no extra latency.
- Register map (address[3:2]):
  - 0: STATUS, read-only. read_data = pins_clean zero-extended. Writes are ignored.
  - 1: IRQ_EN, read/write. Bits [7:0] are rise enables, bits [15:8] are fall enables; other bits read 0.
  - 2: PENDING. Read returns pending bits. Write is write-1-to-clear: clr = write_data[WIDTH-1:0] when write is asserted, else 0.
  - 3: DEB_EN, read/write, bits [WIDTH-1:0].
- `read_data` is combinational from `read` and `address`, with zero-latency reads.
- Writes take effect at the clock edge on which `write` is high.
- read and write in the same cycle is legal: the read returns the pre-write value.
- Disabling an enable does not clear already-pending bits.
- Latency from a pin change (counted in rising clk edges after pins_in changes, SYNC_STAGES=2):
  - `sync` updates at edge 2.
  - In bypass, `pins_clean` updates at edge 3 and PENDING/`irq` at edge 4.
  - Debounced, `pins_clean` updates at edge 2+DEBOUNCE_CYCLES and `irq` at edge 3+DEBOUNCE_CYCLES.
- A reset asserted mid-count or mid-edge drops all state immediately; no edge is reported on release.
- Because `pins_clean` resets to 0, a pin held high through reset produces a rise on the first cycles after release. It sets PENDING only if enabled, and enables are 0 after reset.

Decomposition:
- Shared peripheral package holds the register offset constants: REG_STATUS=0, REG_IRQ_EN=1, REG_PENDING=2, REG_DEB_EN=3.
- One natural sub-module, gpio_debounce_bit, instantiated WIDTH times as an array. It contains the sync chain, counter and clean flop for a single pin, with inputs pin_in, deb_en and output clean.
- The top level holds the edge detect, pending logic, registers and bus decode.

Test Plan:
- Reset with pins_in=8'hFF, then release. Required: read STATUS=0x00 at release; STATUS=0x000000FF by edge 3; PENDING=0; irq=0 throughout.
- Bypass, write IRQ_EN=0x00000001, pin0 rises at cycle 0. Required: pins_clean[0]=1 after edge 3; irq=1 after edge 4; read PENDING=0x01.
- With pin0 pending, write PENDING=0x01 with pin0 steady. Required: irq=0 next cycle. Then repeat with a new rise landing in the same cycle as the clear; PENDING must stay 0x01.
- DEB_EN=0x01, DEBOUNCE_CYCLES=4: a 3-cycle high pulse on pin0 leaves pins_clean[0]=0 and irq=0. A 10-cycle pulse sets pins_clean[0]=1 at edge 6 and returns it to 0 four cycles after the falling input is synchronised.
- IRQ_EN=0x00000100 (pin0 fall only), pin0 rises then falls. Required: no pending bit on the rise; PENDING=0x01 after the fall propagates.
- Assert reset while a debounced pin0 counter is at 2. Required: pins_clean=0, counters 0, irq=0 immediately; no pending set after release.
